// File: rtl/phoneme_sequencer.sv
// phoneme_sequencer: queues phoneme codes, fetches each code's start/end
//   addresses from the flash index table, and starts playback once per
//   phoneme. It also shares the single flash read port with the playback FSM.
// Latency: a code accepted into an empty queue is popped 1 cycle later, and
//   word 0 is requested 2 cycles later. Playback reads are issued the cycle
//   after pb_rd_req if the port is free. pb_rd_done is combinational.
// Backpressure: ph_ready drops when the queue is full, during flush and during
//   reset. Only one flash read is outstanding at a time. Playback reads win
//   over table reads.
// Ports: clk/reset (sync, active high); ph_valid/ph_code/ph_ready (code
//   input); flush; rd_start/rd_addr/rd_done/rd_data (flash reader);
//   pb_rd_req/pb_rd_addr/pb_rd_done/pb_rd_data (playback read path);
//   pb_start/pb_start_addr/pb_finish_addr/pb_done (playback control);
//   seq_idle; entry_err.
// Option: PHONEME_PREFETCH_EN fetches the next table entry during playback.
module phoneme_sequencer #(
   parameter int          FIFO_DEPTH = 8,
   parameter int          CODE_W     = 6,
   parameter logic [23:0] TABLE_BASE = 24'h000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ph_valid,
   input  logic [CODE_W-1:0] ph_code,
   output logic              ph_ready,
   input  logic              flush,
   output logic              rd_start,
   output logic [23:0]       rd_addr,
   input  logic              rd_done,
   input  logic [31:0]       rd_data,
   input  logic              pb_rd_req,
   input  logic [23:0]       pb_rd_addr,
   output logic              pb_rd_done,
   output logic [31:0]       pb_rd_data,
   output logic              pb_start,
   output logic [23:0]       pb_start_addr,
   output logic [23:0]       pb_finish_addr,
   input  logic              pb_done,
   output logic              seq_idle,
   output logic              entry_err
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH_S, S_FETCH_E, S_CHECK, S_PLAYING} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_SEQ, OWN_PB} owner_t;

   function automatic logic [23:0] entry_addr(input logic [CODE_W-1:0] code, input logic word1);
      logic [23:0] off;
      off = {{(24-CODE_W-3){1'b0}}, code, word1, 2'b00};
      return TABLE_BASE + off;
   endfunction

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   logic                pend_q, pend_d;
   logic [23:0]         pend_addr_q, pend_addr_d;
   logic [CODE_W-1:0]   cur_code_q, cur_code_d;
   logic [23:0]         start_q, start_d, end_q, end_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CODE_W-1:0]   fifo_mem_q [FIFO_DEPTH];

   logic fifo_empty, push, pop, port_free, pb_issue, tbl_want, tbl_issue, seq_done;
   logic [23:0] tbl_addr;
   logic [CODE_W-1:0] head_code;
   logic unused_rd_hi;

   assign unused_rd_hi = &{1'b0, rd_data[31:24]};
   assign fifo_empty   = (cnt_q == '0);
   assign ph_ready     = (cnt_q != CNT_W'(FIFO_DEPTH)) && !flush && !reset;
   assign push         = ph_valid && ph_ready;
   assign head_code    = fifo_mem_q[rd_ptr_q];
   assign port_free    = (owner_q == OWN_NONE);
   // A fresh pb_rd_req also blocks table reads so playback wins a same-cycle tie.
   assign pb_issue     = port_free && pend_q;
   assign tbl_issue    = port_free && !pend_q && !pb_rd_req && tbl_want;
   assign seq_done     = rd_done && (owner_q == OWN_SEQ);
   assign pb_rd_done   = rd_done && (owner_q == OWN_PB);
   assign pb_rd_data   = pb_rd_done ? rd_data : 32'h0;
   assign rd_start     = pb_issue || tbl_issue;
   assign rd_addr      = pb_issue ? pend_addr_q : (tbl_issue ? tbl_addr : 24'h0);
   assign pb_start_addr  = start_q;
   assign pb_finish_addr = end_q;

`ifdef PHONEME_PREFETCH_EN
   typedef enum logic [1:0] {PF_IDLE, PF_S, PF_E} pf_t;
   pf_t               pf_q, pf_d;
   logic [CODE_W-1:0] pf_code_q, pf_code_d;
   logic [23:0]       pf_start_q, pf_start_d, hold_start_q, hold_start_d, hold_end_q, hold_end_d;
   logic              hold_vld_q, hold_vld_d;
   assign seq_idle = fifo_empty && (state_q == S_IDLE) && port_free && !pend_q
                     && (pf_q == PF_IDLE) && !hold_vld_q;
`else
   assign seq_idle = fifo_empty && (state_q == S_IDLE) && port_free && !pend_q;
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      cur_code_d  = cur_code_q;
      start_d     = start_q;
      end_d       = end_q;
      pop         = 1'b0;
      pb_start    = 1'b0;
      entry_err   = 1'b0;
      tbl_want    = (state_q == S_FETCH_S) || (state_q == S_FETCH_E);
      tbl_addr    = entry_addr(cur_code_q, state_q == S_FETCH_E);
`ifdef PHONEME_PREFETCH_EN
      pf_d         = pf_q;
      pf_code_d    = pf_code_q;
      pf_start_d   = pf_start_q;
      hold_start_d = hold_start_q;
      hold_end_d   = hold_end_q;
      hold_vld_d   = hold_vld_q;
      // The main FSM and the prefetcher never fetch at the same time.
      if (!tbl_want && pf_q != PF_IDLE) begin
         tbl_want = 1'b1;
         tbl_addr = entry_addr(pf_code_q, pf_q == PF_E);
      end
      if (seq_done && !(state_q == S_FETCH_S || state_q == S_FETCH_E)) begin
         if (pf_q == PF_S) begin
            pf_start_d = rd_data[23:0];
            pf_d       = PF_E;
         end else if (pf_q == PF_E) begin
            hold_start_d = pf_start_q;
            hold_end_d   = rd_data[23:0];
            hold_vld_d   = 1'b1;
            pf_d         = PF_IDLE;
         end
      end
      if (state_q == S_PLAYING && pf_q == PF_IDLE && !hold_vld_q && !fifo_empty && !flush) begin
         pop       = 1'b1;
         pf_code_d = head_code;
         pf_d      = PF_S;
      end
`endif

      unique case (state_q)
         S_IDLE: begin
`ifdef PHONEME_PREFETCH_EN
            if (hold_vld_q) begin
               start_d    = hold_start_q;
               end_d      = hold_end_q;
               hold_vld_d = 1'b0;
               state_d    = S_CHECK;
            end else if (pf_q == PF_IDLE && !fifo_empty && !flush) begin
`else
            if (!fifo_empty && !flush) begin
`endif
               pop        = 1'b1;
               cur_code_d = head_code;
               state_d    = S_FETCH_S;
            end
         end
         S_FETCH_S: if (seq_done) begin
            start_d = rd_data[23:0];
            state_d = S_FETCH_E;
         end
         S_FETCH_E: if (seq_done) begin
            end_d   = rd_data[23:0];
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (start_q < end_q) begin
               pb_start = 1'b1;
               state_d  = S_PLAYING;
            end else begin
               entry_err = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_PLAYING: if (pb_done) begin
`ifdef PHONEME_PREFETCH_EN
            if (hold_vld_q) begin
               start_d    = hold_start_q;
               end_d      = hold_end_q;
               hold_vld_d = 1'b0;
               state_d    = S_CHECK;
            end else begin
               state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      // A stray rd_done with no owner is dropped; issue only happens when free.
      if (rd_done && owner_q != OWN_NONE) owner_d = OWN_NONE;
      else if (pb_issue)                  owner_d = OWN_PB;
      else if (tbl_issue)                 owner_d = OWN_SEQ;

      if (pb_issue) pend_d = 1'b0;
      if (pb_rd_req) begin
         pend_d      = 1'b1;
         pend_addr_d = pb_rd_addr;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      cnt_d = cnt_q + 1'b1;
         else if (pop && !push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= ph_code;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_NONE;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         cur_code_q  <= '0;
         start_q     <= '0;
         end_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
`ifdef PHONEME_PREFETCH_EN
         pf_q         <= PF_IDLE;
         pf_code_q    <= '0;
         pf_start_q   <= '0;
         hold_start_q <= '0;
         hold_end_q   <= '0;
         hold_vld_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         cur_code_q  <= cur_code_d;
         start_q     <= start_d;
         end_q       <= end_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
`ifdef PHONEME_PREFETCH_EN
         pf_q         <= pf_d;
         pf_code_q    <= pf_code_d;
         pf_start_q   <= pf_start_d;
         hold_start_q <= hold_start_d;
         hold_end_q   <= hold_end_d;
         hold_vld_q   <= hold_vld_d;
`endif
      end
   end
endmodule

// File: tb/tb_phoneme_sequencer.sv
// Directed bench for phoneme_sequencer with a behavioural flash reader
// (2-cycle read latency, optionally slow for word 1) and a playback stub.
module tb_phoneme_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ph_valid = 1'b0;
   logic [5:0]  ph_code = '0;
   logic        ph_ready;
   logic        flush = 1'b0;
   logic        rd_start;
   logic [23:0] rd_addr;
   logic        rd_done = 1'b0;
   logic [31:0] rd_data = '0;
   logic        pb_rd_req = 1'b0;
   logic [23:0] pb_rd_addr = '0;
   logic        pb_rd_done;
   logic [31:0] pb_rd_data;
   logic        pb_start;
   logic [23:0] pb_start_addr, pb_finish_addr;
   logic        pb_done = 1'b0;
   logic        seq_idle, entry_err;

   phoneme_sequencer #(.FIFO_DEPTH(8), .CODE_W(6), .TABLE_BASE(24'h000000)) dut (
      .clk(clk), .reset(reset), .ph_valid(ph_valid), .ph_code(ph_code), .ph_ready(ph_ready),
      .flush(flush), .rd_start(rd_start), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
      .pb_rd_req(pb_rd_req), .pb_rd_addr(pb_rd_addr), .pb_rd_done(pb_rd_done), .pb_rd_data(pb_rd_data),
      .pb_start(pb_start), .pb_start_addr(pb_start_addr), .pb_finish_addr(pb_finish_addr),
      .pb_done(pb_done), .seq_idle(seq_idle), .entry_err(entry_err)
   );

   always #5 clk = ~clk;

   int vec = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Flash contents: code 3 valid 0x1000..0x2000, code 5 degenerate,
   // other codes 0x010000 + code*0x100 .. +0x80 with junk in the top byte.
   // Addresses >= 0x200 return playback sample words.
   function automatic logic [31:0] flash_word(input logic [23:0] a);
      logic [5:0]  c;
      logic [23:0] s;
      if (a >= 24'h000200) return {8'h5A, a ^ 24'h00FFFF};
      c = a[8:3];
      if (c == 6'd3) return a[2] ? 32'h00002000 : 32'h00001000;
      if (c == 6'd5) return 32'h00003000;
      s = 24'h010000 + {10'd0, c, 8'd0};
      return a[2] ? {8'hAB, s + 24'h80} : {8'hC3, s};
   endfunction

   function automatic logic [47:0] exp_entry(input logic [5:0] c);
      logic [23:0] s;
      s = 24'h010000 + {10'd0, c, 8'd0};
      return {s, s + 24'h80};
   endfunction

   // Flash reader and playback stubs: sample at negedge, drive after posedge.
   bit          fl_busy = 0, pl_busy = 0, slow_w1 = 0;
   int          fl_cnt = 0, pl_cnt = 0, play_len = 4;
   logic [23:0] fl_addr = '0;
   always @(negedge clk) begin
      if (!reset && rd_start) begin
         fl_busy = 1;
         fl_addr = rd_addr;
         fl_cnt  = (slow_w1 && rd_addr[2]) ? 7 : 1;
      end
      if (!reset && pb_start) begin
         pl_busy = 1;
         pl_cnt  = play_len;
      end
   end
   always @(posedge clk) begin
      #1;
      rd_done = 1'b0;
      pb_done = 1'b0;
      if (fl_busy) begin
         if (fl_cnt == 0) begin
            rd_done = 1'b1;
            rd_data = flash_word(fl_addr);
            fl_busy = 0;
         end else fl_cnt--;
      end
      if (pl_busy) begin
         if (pl_cnt == 0) begin
            pb_done = 1'b1;
            pl_busy = 0;
         end else pl_cnt--;
      end
   end

   // Event logs.
   logic [23:0] rd_log[$];
   int          rd_cyc[$];
   int          done_cyc[$];
   logic [47:0] ps_log[$];
   int          ps_cyc[$];
   int          err_cnt = 0, pbd_cnt = 0;
   logic [31:0] pbd_data = '0;
   always @(negedge clk) begin
      if (!reset) begin
         if (rd_start) begin rd_log.push_back(rd_addr); rd_cyc.push_back(cyc); end
         if (rd_done) done_cyc.push_back(cyc);
         if (pb_start) begin ps_log.push_back({pb_start_addr, pb_finish_addr}); ps_cyc.push_back(cyc); end
         if (entry_err) err_cnt++;
         if (pb_rd_done) begin pbd_cnt++; pbd_data = pb_rd_data; end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs;
      rd_log.delete(); rd_cyc.delete(); done_cyc.delete(); ps_log.delete(); ps_cyc.delete();
      err_cnt = 0; pbd_cnt = 0; pbd_data = '0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 0;
      @(posedge clk);
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (seq_idle && !pl_busy && !fl_busy) ok = 1;
      end
   endtask

   task automatic wait_starts(input int n, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (ps_log.size() >= n) ok = 1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) step();
      @(negedge clk);
      vec++; if (ph_ready !== 1'b0) begin bad++; $display("FAIL rst_ph_ready got %b want 0", ph_ready); end
      step();
      reset = 1'b0;
      @(negedge clk);
      vec++; if (rd_start !== 1'b0) begin bad++; $display("FAIL rst_rd_start got %b want 0", rd_start); end
      vec++; if (pb_start !== 1'b0) begin bad++; $display("FAIL rst_pb_start got %b want 0", pb_start); end
      vec++; if (pb_rd_done !== 1'b0) begin bad++; $display("FAIL rst_pb_rd_done got %b want 0", pb_rd_done); end
      vec++; if (entry_err !== 1'b0) begin bad++; $display("FAIL rst_entry_err got %b want 0", entry_err); end
      vec++; if ({pb_start_addr, pb_finish_addr} !== 48'h0) begin bad++; $display("FAIL rst_pb_addr got %h want 0", {pb_start_addr, pb_finish_addr}); end
      vec++; if (seq_idle !== 1'b1) begin bad++; $display("FAIL rst_seq_idle got %b want 1", seq_idle); end
      vec++; if (ph_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ph_ready got %b want 1", ph_ready); end
   endtask

   task automatic test_single;
      int n; bit ok;
      clear_logs(); play_len = 4;
      step(); ph_valid = 1'b1; ph_code = 6'd3; n = cyc;
      step(); ph_valid = 1'b0;
      wait_idle(200, ok);
      vec++; if (!ok) begin bad++; $display("FAIL single_idle_timeout got busy want idle"); end
      vec++; if (rd_log.size() != 2) begin bad++; $display("FAIL single_rd_count got %0d want 2", rd_log.size()); end
      vec++; if (rd_log.size() < 1 || rd_log[0] !== 24'h000018) begin bad++; $display("FAIL single_w0_addr got %h want 000018", rd_log.size() ? rd_log[0] : 24'hx); end
      vec++; if (rd_log.size() < 2 || rd_log[1] !== 24'h00001C) begin bad++; $display("FAIL single_w1_addr got %h want 00001c", rd_log.size() > 1 ? rd_log[1] : 24'hx); end
      vec++; if (rd_cyc.size() < 1 || rd_cyc[0] != n + 2) begin bad++; $display("FAIL single_w0_latency got cycle %0d want %0d", rd_cyc.size() ? rd_cyc[0] : -1, n + 2); end
      vec++; if (ps_log.size() != 1 || ps_log[0] !== {24'h001000, 24'h002000}) begin bad++; $display("FAIL single_pb_start count %0d got %h want 001000002000", ps_log.size(), ps_log.size() ? ps_log[0] : 48'hx); end
      vec++; if (ps_cyc.size() < 1 || done_cyc.size() < 2 || ps_cyc[0] != done_cyc[1] + 1) begin bad++; $display("FAIL single_check_timing got pb_start cycle %0d want word1 done + 1", ps_cyc.size() ? ps_cyc[0] : -1); end
      vec++; if (seq_idle !== 1'b1) begin bad++; $display("FAIL single_seq_idle got %b want 1", seq_idle); end
      vec++; if (err_cnt != 0 || pbd_cnt != 0) begin bad++; $display("FAIL single_spurious got err %0d pbd %0d want 0 0", err_cnt, pbd_cnt); end
   endtask

   task automatic test_collision;
      int n; bit ok;
      clear_logs(); play_len = 4;
      step(); ph_valid = 1'b1; ph_code = 6'd3; n = cyc;
      step(); ph_valid = 1'b0;
      step(); pb_rd_req = 1'b1; pb_rd_addr = 24'h400100;
      step(); pb_rd_req = 1'b0;
      wait_idle(200, ok);
      vec++; if (!ok) begin bad++; $display("FAIL coll_idle_timeout got busy want idle"); end
      vec++; if (rd_log.size() < 1 || rd_log[0] !== 24'h400100 || rd_cyc[0] != n + 3) begin bad++; $display("FAIL coll_pb_first got %h at %0d want 400100 at %0d", rd_log.size() ? rd_log[0] : 24'hx, rd_cyc.size() ? rd_cyc[0] : -1, n + 3); end
      vec++; if (rd_log.size() < 2 || rd_log[1] !== 24'h000018 || done_cyc.size() < 1 || rd_cyc[1] != done_cyc[0] + 1) begin bad++; $display("FAIL coll_tbl_after got %h want 000018 one cycle after pb rd_done", rd_log.size() > 1 ? rd_log[1] : 24'hx); end
      vec++; if (pbd_cnt != 1) begin bad++; $display("FAIL coll_pb_rd_done_count got %0d want 1", pbd_cnt); end
      vec++; if (pbd_data !== 32'h5A40FEFF) begin bad++; $display("FAIL coll_pb_rd_data got %h want 5a40feff", pbd_data); end
      vec++; if (ps_log.size() != 1 || ps_log[0] !== {24'h001000, 24'h002000}) begin bad++; $display("FAIL coll_pb_start count %0d want 1 with 001000/002000", ps_log.size()); end
   endtask

   task automatic test_invalid;
      bit ok;
      clear_logs(); play_len = 4;
      step(); ph_valid = 1'b1; ph_code = 6'd5;
      step(); ph_code = 6'd3;
      step(); ph_valid = 1'b0;
      wait_idle(300, ok);
      vec++; if (!ok) begin bad++; $display("FAIL inv_idle_timeout got busy want idle"); end
      vec++; if (err_cnt != 1) begin bad++; $display("FAIL inv_entry_err got %0d pulses want 1", err_cnt); end
      vec++; if (ps_log.size() != 1 || ps_log[0] !== {24'h001000, 24'h002000}) begin bad++; $display("FAIL inv_next_code count %0d want 1 with 001000/002000", ps_log.size()); end
      vec++; if (rd_log.size() != 4 || rd_log[2] !== 24'h000018) begin bad++; $display("FAIL inv_reads got %0d reads want 4 with third at 000018", rd_log.size()); end
   endtask

   task automatic test_queue_full;
      bit ok; logic [5:0] c;
      clear_logs(); play_len = 30;
      step(); ph_valid = 1'b1; ph_code = 6'd1;
      step(); ph_valid = 1'b0;
      wait_starts(1, 50, ok);
      vec++; if (!ok) begin bad++; $display("FAIL full_first_start_timeout got none want pb_start"); end
      step();
      for (int i = 0; i < 8; i++) begin
         ph_valid = 1'b1; ph_code = 6'(10 + i);
         step();
      end
      ph_valid = 1'b0;
      @(negedge clk);
      vec++; if (ph_ready !== 1'b0) begin bad++; $display("FAIL full_ph_ready got %b want 0", ph_ready); end
      step(); ph_valid = 1'b1; ph_code = 6'd20;
      step(); ph_valid = 1'b0;
      wait_idle(2000, ok);
      vec++; if (!ok) begin bad++; $display("FAIL full_idle_timeout got busy want idle"); end
      vec++; if (ps_log.size() != 9) begin bad++; $display("FAIL full_start_count got %0d want 9", ps_log.size()); end
      for (int i = 0; i < 9; i++) begin
         c = (i == 0) ? 6'd1 : 6'(9 + i);
         vec++;
         if (i >= ps_log.size() || ps_log[i] !== exp_entry(c)) begin
            bad++; $display("FAIL full_order[%0d] got %h want %h", i, i < ps_log.size() ? ps_log[i] : 48'hx, exp_entry(c));
         end
      end
   endtask

   task automatic test_flush;
      bit ok;
      clear_logs(); play_len = 30;
      step(); ph_valid = 1'b1; ph_code = 6'd1;
      step(); ph_valid = 1'b0;
      wait_starts(1, 50, ok);
      step();
      for (int i = 0; i < 3; i++) begin
         ph_valid = 1'b1; ph_code = 6'(6 + i);
         step();
      end
      flush = 1'b1; ph_code = 6'd9;
      @(negedge clk);
      vec++; if (ph_ready !== 1'b0) begin bad++; $display("FAIL flush_ph_ready got %b want 0", ph_ready); end
      step(); flush = 1'b0; ph_valid = 1'b0;
      wait_idle(500, ok);
      vec++; if (!ok) begin bad++; $display("FAIL flush_idle_timeout got busy want idle"); end
      vec++; if (ps_log.size() != 1 || ps_log[0] !== exp_entry(6'd1)) begin bad++; $display("FAIL flush_only_current got %0d starts want 1", ps_log.size()); end
      vec++; if (rd_log.size() != 2) begin bad++; $display("FAIL flush_reads got %0d want 2", rd_log.size()); end
   endtask

   task automatic test_reset_mid;
      bit ok;
      clear_logs(); play_len = 4; slow_w1 = 1;
      step(); ph_valid = 1'b1; ph_code = 6'd3;
      step(); ph_valid = 1'b0;
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (rd_log.size() >= 2) ok = 1;
      end
      vec++; if (!ok) begin bad++; $display("FAIL rmid_w1_timeout got %0d reads want 2", rd_log.size()); end
      step(); reset = 1'b1;
      step(); reset = 1'b0;
      @(negedge clk);
      vec++; if ({rd_start, pb_start, pb_rd_done, entry_err} !== 4'b0000) begin bad++; $display("FAIL rmid_pulses got %b want 0000", {rd_start, pb_start, pb_rd_done, entry_err}); end
      vec++; if ({pb_start_addr, pb_finish_addr} !== 48'h0) begin bad++; $display("FAIL rmid_pb_addr got %h want 0", {pb_start_addr, pb_finish_addr}); end
      vec++; if (rd_addr !== 24'h0) begin bad++; $display("FAIL rmid_rd_addr got %h want 0", rd_addr); end
      repeat (12) step();
      @(negedge clk);
      vec++; if (pbd_cnt != 0) begin bad++; $display("FAIL rmid_late_pb_rd_done got %0d want 0", pbd_cnt); end
      vec++; if (rd_log.size() != 2 || ps_log.size() != 0) begin bad++; $display("FAIL rmid_no_activity got %0d reads %0d starts want 2 0", rd_log.size(), ps_log.size()); end
      vec++; if (seq_idle !== 1'b1) begin bad++; $display("FAIL rmid_seq_idle got %b want 1", seq_idle); end
      slow_w1 = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_collision();
      test_invalid();
      test_queue_full();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
